// File: rtl/stream_reduce_expand.sv
// Expands one reduced word into a framed burst of 2**LOG2_COUNT samples whose
// sum reproduces the word exactly: COUNT-1 copies of floor(X/COUNT), then the remainder-adjusted tail.
module stream_reduce_expand #(
  parameter int WIDTH      = 32,
  parameter int LOG2_COUNT = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    busy
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [LOG2_COUNT-1:0] LAST_IDX = '1;

  state_t                  state_reg, state_next;
  logic [LOG2_COUNT-1:0]   count_reg, count_next, count_inc;
  logic signed [WIDTH-1:0] quot_reg, quot_next;
  logic signed [WIDTH-1:0] tail_reg, tail_next;
  logic signed [WIDTH-1:0] data_reg, data_next;
  logic signed [WIDTH-1:0] new_quot, new_tail;
  logic [WIDTH-1:0]        new_rem;
  logic                    at_last, in_xfer, out_xfer;

  // Floor quotient plus the non-negative remainder; quot + rem never exceeds X
  // in magnitude direction, so the tail sample cannot overflow.
  assign new_quot = in_data >>> LOG2_COUNT;
  assign new_rem  = {{(WIDTH-LOG2_COUNT){1'b0}}, in_data[LOG2_COUNT-1:0]};
  assign new_tail = new_quot + signed'(new_rem);

  assign count_inc = count_reg + 1'b1;
  assign at_last   = (state_reg == EMIT) && (count_reg == LAST_IDX);

  assign out_valid = (state_reg == EMIT);
  assign busy      = (state_reg == EMIT);
  assign out_last  = at_last;
  assign out_data  = data_reg;
  // Accepting during the final transfer lets consecutive bursts run without a bubble.
  assign in_ready  = (state_reg == IDLE) || (at_last && out_ready);

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    quot_next  = quot_reg;
    tail_next  = tail_reg;
    data_next  = data_reg;
    if (in_xfer) begin
      state_next = EMIT;
      count_next = '0;
      quot_next  = new_quot;
      tail_next  = new_tail;
      data_next  = (LAST_IDX == '0) ? new_tail : new_quot;
    end else if (out_xfer) begin
      if (at_last) begin
        state_next = IDLE;
      end else begin
        count_next = count_inc;
        data_next  = (count_inc == LAST_IDX) ? tail_reg : quot_reg;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      count_reg <= '0;
      quot_reg  <= '0;
      tail_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      quot_reg  <= quot_next;
      tail_reg  <= tail_next;
      data_reg  <= data_next;
    end
  end

endmodule

// File: tb/tb_stream_reduce_expand.sv
// Directed bench for stream_reduce_expand: every accepted word pushes its
// expected burst into a queue, every output transfer pops and compares.
module tb_stream_reduce_expand;

  logic               CLK = 1'b0;
  logic               RST;
  logic               in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic signed [31:0] in_data, out_data;
  logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic signed [31:0] b_in_data, b_out_data;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          total_checks = 0;
  int          passed_checks = 0;
  logic        accepted = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;
  logic        contig = 1'b0;

  always #5 CLK = ~CLK;

  stream_reduce_expand #(.WIDTH(32), .LOG2_COUNT(4)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  stream_reduce_expand #(.WIDTH(32), .LOG2_COUNT(1)) dut_b (
    .CLK(CLK), .RST(RST),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected burst from floor division of X by 16; tail absorbs the remainder.
  task automatic push_burst(input logic signed [31:0] d);
    longint x, q;
    exp_t   e;
    x = longint'(d);
    if (x >= 0) q = x / 16;
    else q = -((-x + 15) / 16);
    for (int i = 0; i < 15; i++) begin
      e.data = q[31:0];
      e.last = 1'b0;
      sb.push_back(e);
    end
    x = x - 15 * q;
    e.data = x[31:0];
    e.last = 1'b1;
    sb.push_back(e);
    $display("accept in_data=%0d, burst queued (sb depth %0d)", d, sb.size());
  endtask

  // One clock: inspect handshakes at the falling edge, then advance past the rising edge.
  task automatic step();
    exp_t e;
    @(negedge CLK);
    accepted = 1'b0;
    if (!RST) begin
      if (stall_prev) begin
        check("stall_data", out_data, stall_data);
        check("stall_last", {31'd0, out_last}, {31'd0, stall_last});
      end
      if (contig && sb.size() > 0) check("no_bubble", {31'd0, out_valid}, 32'd1);
      if (out_valid && !(out_last && out_ready)) check("in_ready_low", {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        check("out_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("data", out_data, e.data);
          check("last", {31'd0, out_last}, {31'd0, e.last});
          $display("sample out_data=%0d out_last=%0b", out_data, out_last);
        end
      end
      if (in_valid && in_ready) begin
        push_burst(in_data);
        accepted = 1'b1;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
    end else begin
      stall_prev = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic signed [31:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    step();
    while (!accepted && n < 40) begin
      step();
      n++;
    end
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // mode 0: out_ready held high; mode 1: stall-heavy pseudo-random pattern.
  task automatic drain(input int mode);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 300) begin
      if (mode == 0) out_ready = 1'b1;
      else out_ready = (n % 4 == 0 || n % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      step();
      n++;
    end
    check("drain_timeout", sb.size(), 32'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    RST = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 120 -> 7 x15, 15 last; first sample one cycle after accept
    out_ready = 1'b1;
    send(120);
    check("latency_valid", {31'd0, out_valid}, 32'd1);
    check("latency_busy", {31'd0, busy}, 32'd1);
    drain(0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_valid", {31'd0, out_valid}, 32'd0);

    // negative word: floor semantics
    send(-17);
    drain(0);

    // back-to-back words with no bubble between bursts
    send(16);
    contig = 1'b1;
    send(33);
    drain(0);
    contig = 1'b0;

    // backpressure
    send(100);
    drain(1);

    // reset mid-burst abandons it
    send(100);
    repeat (4) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    sb.delete();
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    send(32);
    drain(0);

    // LOG2_COUNT = 1 at the positive extreme
    b_in_valid = 1'b1;
    b_in_data  = 32'h7FFF_FFFF;
    b_out_ready = 1'b1;
    @(negedge CLK);
    check("b_in_ready", {31'd0, b_in_ready}, 32'd1);
    @(posedge CLK);
    #1;
    b_in_valid = 1'b0;
    check("b_s0_data", b_out_data, 32'h3FFF_FFFF);
    check("b_s0_last", {31'd0, b_out_last}, 32'd0);
    @(posedge CLK);
    #1;
    check("b_s1_data", b_out_data, 32'h4000_0000);
    check("b_s1_last", {31'd0, b_out_last}, 32'd1);
    $display("b burst: 3fffffff then 40000000 (last)");
    @(posedge CLK);
    #1;
    check("b_idle_valid", {31'd0, b_out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
